// File: rtl/window_stream_pkg.sv
// Shared helpers for the sliding-window streamer: counter sizing, window indexing and the
// pixel/window array types of the default configuration.
package window_stream_pkg;

    localparam int unsigned DefKernelWidth = 3;
    localparam int unsigned DefWidthIn     = 8;
    localparam int unsigned DefChannels    = 1;

    typedef logic [DefWidthIn-1:0] pixel_t;
    typedef pixel_t [DefChannels-1:0] pixel_vec_t;
    typedef pixel_t [DefKernelWidth*DefKernelWidth-1:0] kernel_t;
    typedef kernel_t [DefChannels-1:0] window_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Row-major position inside a KxK window.
    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                            input int unsigned k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Enable-driven delay line: data_o is the word written Depth enables ago.
// Storage has no reset so it can map onto distributed RAM.
module line_buffer
    import window_stream_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 640
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    localparam int unsigned PtrW = cnt_width(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  ptr_q;

    // Read the slot about to be overwritten: it holds the oldest word.
    assign data_o = mem_q[ptr_q];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/window_stream.sv
// Streams KxK pixel windows from a raster pixel stream using K-1 line buffers and a
// single registered output stage with valid/ready handshaking.
module window_stream
    import window_stream_pkg::*;
#(
    parameter int unsigned KernelWidth = 3,
    parameter int unsigned WidthIn     = 8,
    parameter int unsigned Channels    = 1,
    parameter int unsigned LineWidth   = 640,
    localparam int unsigned KernelArea = KernelWidth * KernelWidth
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          in_valid_i,
    output logic                                          in_ready_o,
    input  logic [Channels-1:0][WidthIn-1:0]              in_data_i,
    input  logic                                          in_last_i,
    output logic                                          out_valid_o,
    input  logic                                          out_ready_i,
    output logic [Channels-1:0][KernelArea-1:0][WidthIn-1:0] window_o,
    output logic                                          out_last_o
);

    localparam int unsigned ColW = cnt_width(LineWidth);
    localparam int unsigned RowW = cnt_width(KernelWidth);
    localparam int unsigned LbW  = Channels * WidthIn;

    typedef logic [Channels-1:0][KernelArea-1:0][WidthIn-1:0] win_t;

    win_t            win_q, win_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic            in_fire, out_fire, qualify;

    logic [LbW-1:0] lb_in  [KernelWidth-1];
    logic [LbW-1:0] lb_out [KernelWidth-1];

    assign in_ready_o  = out_ready_i | ~valid_q;
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = valid_q & out_ready_i;
    assign out_valid_o = valid_q;
    assign out_last_o  = last_q;
    assign window_o    = win_q;

    // Columns left of K-1 would pull pixels from the previous line into the window.
    assign qualify = (col_q >= ColW'(KernelWidth - 1)) && (row_q >= RowW'(KernelWidth - 1));

    for (genvar j = 0; j < KernelWidth - 1; j++) begin : g_lb
        if (j == 0) begin : g_head
            assign lb_in[j] = in_data_i;
        end else begin : g_chain
            assign lb_in[j] = lb_out[j-1];
        end

        line_buffer #(
            .Width (LbW),
            .Depth (LineWidth)
        ) u_line_buffer (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (in_fire),
            .data_i (lb_in[j]),
            .data_o (lb_out[j])
        );
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_fire) begin
            if (in_last_i) begin
                col_d = '0;
                row_d = '0;
            end else if (col_q == ColW'(LineWidth - 1)) begin
                col_d = '0;
                if (row_q != RowW'(KernelWidth - 1)) begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        win_d   = win_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (in_fire) begin
            for (int ch = 0; ch < Channels; ch++) begin
                for (int r = 0; r < KernelWidth; r++) begin
                    for (int c = 0; c < KernelWidth - 1; c++) begin
                        win_d[ch][win_idx(r, c, KernelWidth)] =
                            win_q[ch][win_idx(r, c + 1, KernelWidth)];
                    end
                end
                win_d[ch][win_idx(KernelWidth - 1, KernelWidth - 1, KernelWidth)] = in_data_i[ch];
                // Line buffer j-1 supplies the pixel j lines above the incoming one.
                for (int j = 1; j < KernelWidth; j++) begin
                    win_d[ch][win_idx(KernelWidth - 1 - j, KernelWidth - 1, KernelWidth)] =
                        lb_out[j-1][ch*WidthIn +: WidthIn];
                end
            end
            valid_d = qualify;
            last_d  = qualify & in_last_i;
        end else if (out_fire) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            win_q   <= win_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

endmodule

// File: tb/tb_window_stream.sv
// Scoreboard bench for window_stream with K=3, LineWidth=4, two channels (ch1 = 255 - ch0).
module tb_window_stream;

    localparam int unsigned K  = 3;
    localparam int unsigned LW = 4;
    localparam int unsigned CH = 2;
    localparam int unsigned W  = 8;

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [CH-1:0][W-1:0]      in_data;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [CH-1:0][K*K-1:0][W-1:0] window;
    logic                      out_last;

    typedef struct {
        logic [K*K-1:0][W-1:0] w0;
        logic                  last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   rand_ready = 0;

    window_stream #(
        .KernelWidth (K),
        .WidthIn     (W),
        .Channels    (CH),
        .LineWidth   (LW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .window_o    (window),
        .out_last_o  (out_last)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [K*K-1:0][W-1:0] invert(input logic [K*K-1:0][W-1:0] w);
        logic [K*K-1:0][W-1:0] r;
        for (int i = 0; i < K*K; i++) r[i] = 8'(255 - int'(w[i]));
        return r;
    endfunction

    // Window of pixel idx in a 4-wide frame whose pixel values are base+index.
    task automatic push_expect(input int base, input int idx, input bit last);
        exp_t e;
        if ((idx % LW) >= K - 1 && (idx / LW) >= K - 1) begin
            for (int rr = 0; rr < K; rr++)
                for (int cc = 0; cc < K; cc++)
                    e.w0[rr*K+cc] = 8'(base + idx - (K - 1 - rr) * LW - (K - 1 - cc));
            e.last = last;
            exp_q.push_back(e);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic send_pixel(input int base, input int idx, input bit last);
        bit ok = 0;
        in_valid   = 1;
        in_data[0] = 8'(base + idx);
        in_data[1] = 8'(255 - base - idx);
        in_last    = last;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 (pixel %0d)", idx);
        end else begin
            push_expect(base, idx, last);
            @(posedge clk); #1;
        end
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic frame(input int base, input bit with_last, input bit gaps);
        for (int idx = 0; idx < 16; idx++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_pixel(base, idx, with_last && idx == 15);
        end
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pops on every accepted window.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window: got %h expected none", window[0]);
                end else begin
                    e = exp_q.pop_front();
                    check("window_ch0", window[0], e.w0);
                    check("window_ch1", window[1], invert(e.w0));
                    check("out_last", out_last, e.last);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        logic [CH-1:0][K*K-1:0][W-1:0] snap;
        rst = 1; in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        check("reset_window", window, 0);
        check("reset_in_ready", in_ready, 1);
        rst = 0;
        @(posedge clk); #1;

        // Plain ramp, no in_last: four windows, first one right after pixel 10.
        for (int idx = 0; idx < 16; idx++) begin
            send_pixel(0, idx, 0);
            if (idx == 9)  check("latency_before", out_valid, 0);
            if (idx == 10) check("latency_first", out_valid, 1);
        end
        drain("drain_ramp");
        rst = 1;
        @(posedge clk); #1;
        rst = 0;

        // Two back-to-back frames terminated by in_last.
        frame(16, 1, 0);
        frame(32, 1, 0);
        drain("drain_last_frames");

        // Backpressure right after the first valid window.
        fork
            frame(48, 1, 0);
            begin
                int n = 0;
                while (!out_valid && n < 100) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("stall_valid_seen", out_valid, 1);
                out_ready = 0;
                snap = window;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_window", window, snap);
                    check("stall_out_valid", out_valid, 1);
                    check("stall_in_ready", in_ready, 0);
                    @(posedge clk); #1;
                end
                out_ready = 1;
            end
        join
        drain("drain_stall");

        // Random gaps on both sides over three frames.
        rand_ready = 1;
        frame(64, 1, 1);
        frame(80, 1, 1);
        frame(96, 1, 1);
        rand_ready = 0;
        out_ready = 1;
        drain("drain_random");

        // Asynchronous reset mid-frame, then a clean ramp.
        for (int idx = 0; idx < 10; idx++) send_pixel(112, idx, 0);
        #1 rst = 1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_out_last", out_last, 0);
        check("async_window", window, 0);
        @(posedge clk); #1;
        rst = 0;
        frame(0, 0, 0);
        drain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
